// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - conv -> maxpool batch sequencer with start/busy/done control
// Optional per-phase watchdog and ERR state are built in when CNN_SEQ_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module cnn_layer_sequencer #(
   parameter int FRAME_W = 8,
   parameter int CYC_W   = 32,
   parameter int TIMEOUT = 1 << 22
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_abort,
   input  logic [FRAME_W-1:0] i_num_frames,
   input  logic               i_done_conv,
   input  logic               i_done_pool,
   output logic               o_conv_en,
   output logic               o_pool_en,
   output logic               o_busy,
   output logic               o_done,
   output logic [FRAME_W-1:0] o_frame_idx,
   output logic [CYC_W-1:0]   o_busy_cycles,
   output logic               o_error
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CONV = 3'd1,
      S_POOL = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("cnn_layer_sequencer: TIMEOUT must be at least 1");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [FRAME_W-1:0] r_frames_m1;
   logic [FRAME_W-1:0] r_frame_idx;
   logic [CYC_W-1:0]   r_busy_cycles;
   logic               r_conv_en;
   logic               r_pool_en;
   logic               r_busy;
   logic               r_done;
   logic               w_conv_en_nxt;
   logic               w_pool_en_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_last_frame;
   logic               w_start_ok;
   logic               w_accept;
   logic               w_wd_hit;

   assign w_last_frame = (r_frame_idx == r_frames_m1);
   assign w_accept     = (r_state == S_IDLE) && (w_state_nxt == S_CONV);

`ifdef CNN_SEQ_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_error;

   // Counter restarts on every state change, so each CONV and POOL phase gets a fresh budget.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wd_cnt <= '0;
      end else if (w_state_nxt != r_state) begin
         r_wd_cnt <= '0;
      end else if ((r_state == S_CONV) || (r_state == S_POOL)) begin
         r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_error <= 1'b0;
      end else if (w_state_nxt == S_ERR) begin
         r_error <= 1'b1;
      end
   end

   assign w_wd_hit   = (r_wd_cnt == WD_W'(TIMEOUT - 1));
   assign w_start_ok = ~r_error;
   assign o_error    = r_error;
`else
   assign w_wd_hit   = 1'b0;
   assign w_start_ok = 1'b1;
   assign o_error    = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (i_abort && (r_state != S_IDLE)) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (i_start && !i_abort && w_start_ok) w_state_nxt = S_CONV;
            S_CONV: begin
               if (i_done_conv)   w_state_nxt = S_POOL;
               else if (w_wd_hit) w_state_nxt = S_ERR;
            end
            S_POOL: begin
               if (i_done_pool)   w_state_nxt = S_GAP;
               else if (w_wd_hit) w_state_nxt = S_ERR;
            end
            S_GAP:  w_state_nxt = w_last_frame ? S_DONE : S_CONV;
            S_DONE: w_state_nxt = S_IDLE;
            S_ERR:  w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so they change with the state.
   always_comb begin
      w_conv_en_nxt = (w_state_nxt == S_CONV);
      w_pool_en_nxt = (w_state_nxt == S_POOL);
      w_busy_nxt    = (w_state_nxt == S_CONV) || (w_state_nxt == S_POOL) ||
                      (w_state_nxt == S_GAP);
      w_done_nxt    = (w_state_nxt == S_DONE);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_conv_en <= 1'b0;
         r_pool_en <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_conv_en <= w_conv_en_nxt;
         r_pool_en <= w_pool_en_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_frames_m1   <= '0;
         r_frame_idx   <= '0;
         r_busy_cycles <= '0;
      end else begin
         if (w_accept) begin
            r_frames_m1   <= (i_num_frames == '0) ? '0 : i_num_frames - FRAME_W'(1);
            r_frame_idx   <= '0;
            r_busy_cycles <= '0;
         end else begin
            if ((r_state == S_GAP) && (w_state_nxt == S_CONV)) begin
               r_frame_idx <= r_frame_idx + FRAME_W'(1);
            end
            if (r_busy && (r_busy_cycles != '1)) begin
               r_busy_cycles <= r_busy_cycles + CYC_W'(1);
            end
         end
      end
   end

   assign o_conv_en     = r_conv_en;
   assign o_pool_en     = r_pool_en;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_frame_idx   = r_frame_idx;
   assign o_busy_cycles = r_busy_cycles;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - self-checking bench for cnn_layer_sequencer
// Watchdog scenario is exercised when CNN_SEQ_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_cnn_layer_sequencer;

   localparam int FW = 8;
   localparam int CW = 32;
   localparam int TO = 64;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [FW-1:0] num_frames;
   logic          done_conv;
   logic          done_pool;
   logic          dc_m;
   logic          dp_m;
   logic          stray_pool;
   logic          conv_en;
   logic          pool_en;
   logic          busy;
   logic          done;
   logic          error;
   logic [FW-1:0] frame_idx;
   logic [CW-1:0] busy_cycles;

   int lat_c[256];
   int lat_p[256];
   int n_vec;
   int n_err;
   int cc, pc, cfr, pfr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign done_conv = dc_m;
   assign done_pool = dp_m | stray_pool;

   cnn_layer_sequencer #(.FRAME_W(FW), .CYC_W(CW), .TIMEOUT(TO)) u_dut (
      .i_clk         (clk),
      .i_reset       (rst_n),
      .i_start       (start),
      .i_abort       (abort),
      .i_num_frames  (num_frames),
      .i_done_conv   (done_conv),
      .i_done_pool   (done_pool),
      .o_conv_en     (conv_en),
      .o_pool_en     (pool_en),
      .o_busy        (busy),
      .o_done        (done),
      .o_frame_idx   (frame_idx),
      .o_busy_cycles (busy_cycles),
      .o_error       (error)
   );

   // Engine models: done rises lat cycles after en rises, seen by the sequencer one edge later.
   always @(negedge clk) begin
      if (rst_n !== 1'b1 || busy !== 1'b1) begin
         cc = 0; pc = 0; cfr = 0; pfr = 0; dc_m = 1'b0; dp_m = 1'b0;
      end else begin
         if (conv_en) begin
            cc++;
            dc_m = (cc > lat_c[cfr % 256]);
         end else begin
            if (cc != 0) cfr++;
            cc = 0; dc_m = 1'b0;
         end
         if (pool_en) begin
            pc++;
            dp_m = (pc > lat_p[pfr % 256]);
         end else begin
            if (pc != 0) pfr++;
            pc = 0; dp_m = 1'b0;
         end
      end
   end

   task automatic set_lats(input int n, input int cmin);
      for (int i = 0; i < n; i++) begin
         lat_c[i] = int'($urandom_range(25, cmin));
         lat_p[i] = int'($urandom_range(15, 1));
      end
   endtask

   task automatic do_batch(input int nf, input bit mid_start, input bit stray, input string tag);
      int ef, exp_bc, cyc, rises, dones;
      bit prev_c, prev_p, fin, bad_err, bad_gap, bad_hand, bad_idx;
      ef = (nf == 0) ? 1 : nf;
      exp_bc = 0;
      for (int i = 0; i < ef; i++) exp_bc += lat_c[i] + lat_p[i] + 3;
      @(negedge clk); start = 1'b1; num_frames = FW'(nf);
      @(negedge clk); start = 1'b0;
      n_vec++;
      if (conv_en !== 1'b1 || busy !== 1'b1 || frame_idx !== '0) begin
         n_err++;
         $display("FAIL %s start_latency: conv_en=%0b busy=%0b idx=%0d expected 1 1 0", tag, conv_en, busy, frame_idx);
      end
      if (stray) stray_pool = 1'b1;
      prev_c = 1'b1; prev_p = 1'b0; rises = 1; dones = 0; fin = 1'b0; cyc = 0;
      bad_err = 1'b0; bad_gap = 1'b0; bad_hand = 1'b0; bad_idx = 1'b0;
      while (!fin && cyc < 20000) begin
         @(negedge clk); cyc++;
         if (start) start = 1'b0;
         if (stray && cyc == 3) stray_pool = 1'b0;
         if (error !== 1'b0) bad_err = 1'b1;
         if (conv_en && !prev_c) begin
            if (frame_idx !== FW'(rises)) bad_idx = 1'b1;
            rises++;
         end
         if (pool_en && !prev_p) begin
            if (conv_en || !prev_c) bad_hand = 1'b1;
            if (mid_start && rises == 1) start = 1'b1;
         end
         if (!pool_en && prev_p && (conv_en || !busy)) bad_gap = 1'b1;
         if (done) begin
            dones++;
            fin = 1'b1;
         end
         prev_c = conv_en; prev_p = pool_en;
      end
      n_vec++;
      if (!fin) begin
         n_err++;
         $display("FAIL %s done_timeout: got no done after %0d cycles expected done", tag, cyc);
      end
      n_vec++;
      if (busy_cycles !== CW'(exp_bc)) begin
         n_err++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cycles, exp_bc);
      end
      n_vec++;
      if (frame_idx !== FW'(ef - 1) || busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s final_idx: got idx=%0d busy=%0b expected %0d 0", tag, frame_idx, busy, ef - 1);
      end
      n_vec++;
      if (rises !== ef || bad_idx) begin
         n_err++;
         $display("FAIL %s frame_seq: got %0d frames (idx_err=%0b) expected %0d", tag, rises, bad_idx, ef);
      end
      n_vec++;
      if (bad_gap || bad_hand || bad_err) begin
         n_err++;
         $display("FAIL %s enable_seq: gap_err=%0b hand_err=%0b error_seen=%0b expected 0 0 0", tag, bad_gap, bad_hand, bad_err);
      end
      @(negedge clk);
      if (done) dones++;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) dones += 10;
      end
      n_vec++;
      if (dones !== 1) begin
         n_err++;
         $display("FAIL %s done_pulse: got %0d pulse score expected 1", tag, dones);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b1; abort = 1'b0; num_frames = 8'd3; stray_pool = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({conv_en, pool_en, busy, done, error} !== 5'b0 || frame_idx !== '0 || busy_cycles !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got en=%0b%0b busy=%0b done=%0b err=%0b idx=%0d bc=%0d expected all 0",
                  conv_en, pool_en, busy, done, error, frame_idx, busy_cycles);
      end
      rst_n = 1'b1; start = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || conv_en !== 1'b0 || busy_cycles !== '0) begin
         n_err++;
         $display("FAIL reset_idle: got busy=%0b conv_en=%0b bc=%0d expected 0 0 0", busy, conv_en, busy_cycles);
      end
   endtask

   task automatic test_single;
      lat_c[0] = 20; lat_p[0] = 10;
      do_batch(1, 1'b0, 1'b0, "single");
   endtask

   task automatic test_multi;
      set_lats(3, 1);
      do_batch(3, 1'b0, 1'b0, "multi3");
   endtask

   task automatic test_zero_frames;
      set_lats(2, 6);
      do_batch(0, 1'b1, 1'b1, "zero_frames");
   endtask

   task automatic test_random;
      for (int b = 0; b < 6; b++) begin
         set_lats(6, 1);
         do_batch(int'($urandom_range(6, 1)), 1'b1, 1'b0, "random");
      end
   endtask

   task automatic test_abort;
      int exp_bc, rises, guard;
      bit prev_c, seen_done;
      set_lats(4, 1);
      exp_bc = lat_c[0] + lat_p[0] + 3 + lat_c[1] + 1 + 1;
      @(negedge clk); start = 1'b1; num_frames = 8'd4;
      @(negedge clk); start = 1'b0;
      rises = 1; prev_c = 1'b1; guard = 0;
      while (!(pool_en && rises == 2) && guard < 2000) begin
         @(negedge clk); guard++;
         if (conv_en && !prev_c) rises++;
         prev_c = conv_en;
      end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      n_vec++;
      if ({conv_en, pool_en, busy, done} !== 4'b0 || frame_idx !== 8'd1) begin
         n_err++;
         $display("FAIL abort_state: got en=%0b%0b busy=%0b done=%0b idx=%0d expected 0 0 0 0 1",
                  conv_en, pool_en, busy, done, frame_idx);
      end
      n_vec++;
      if (busy_cycles !== CW'(exp_bc)) begin
         n_err++;
         $display("FAIL abort_busy_cycles: got %0d expected %0d", busy_cycles, exp_bc);
      end
      seen_done = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      n_vec++;
      if (seen_done || busy_cycles !== CW'(exp_bc) || frame_idx !== 8'd1) begin
         n_err++;
         $display("FAIL abort_hold: got activity=%0b bc=%0d idx=%0d expected 0 %0d 1", seen_done, busy_cycles, frame_idx, exp_bc);
      end
      set_lats(4, 1);
      do_batch(4, 1'b0, 1'b0, "after_abort");
   endtask

   task automatic test_async_reset;
      set_lats(2, 10);
      @(negedge clk); start = 1'b1; num_frames = 8'd2;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({conv_en, pool_en, busy, done, error} !== 5'b0 || frame_idx !== '0 || busy_cycles !== '0) begin
         n_err++;
         $display("FAIL async_reset: got en=%0b%0b busy=%0b done=%0b err=%0b idx=%0d bc=%0d expected all 0",
                  conv_en, pool_en, busy, done, error, frame_idx, busy_cycles);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

`ifdef CNN_SEQ_WATCHDOG_EN
   task automatic test_watchdog;
      int ccnt, guard;
      lat_c[0] = 100000; lat_p[0] = 1;
      @(negedge clk); start = 1'b1; num_frames = 8'd1;
      @(negedge clk); start = 1'b0;
      ccnt = 0; guard = 0;
      while (error !== 1'b1 && guard < 500) begin
         if (conv_en) ccnt++;
         @(negedge clk); guard++;
      end
      n_vec++;
      if (error !== 1'b1 || ccnt !== TO || {conv_en, pool_en, busy} !== 3'b0) begin
         n_err++;
         $display("FAIL wd_trip: got err=%0b conv_cycles=%0d en_busy=%0b%0b%0b expected 1 %0d 000",
                  error, ccnt, conv_en, pool_en, busy, TO);
      end
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || conv_en !== 1'b0 || error !== 1'b1) begin
         n_err++;
         $display("FAIL wd_start_in_err: got busy=%0b conv_en=%0b err=%0b expected 0 0 1", busy, conv_en, error);
      end
      abort = 1'b1;
      @(negedge clk); abort = 1'b0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      n_vec++;
      if (error !== 1'b1 || busy !== 1'b0 || conv_en !== 1'b0) begin
         n_err++;
         $display("FAIL wd_abort_sticky: got err=%0b busy=%0b conv_en=%0b expected 1 0 0", error, busy, conv_en);
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (error !== 1'b0) begin
         n_err++;
         $display("FAIL wd_reset_clears: got err=%0b expected 0", error);
      end
      rst_n = 1'b1;
      @(negedge clk);
      set_lats(2, 1);
      do_batch(2, 1'b0, 1'b0, "wd_recover");
   endtask
`else
   task automatic test_no_watchdog;
      lat_c[0] = 150; lat_p[0] = 90;
      do_batch(1, 1'b0, 1'b0, "long_phase");
   endtask
`endif

   initial begin
      n_vec = 0; n_err = 0;
      test_reset();
      test_single();
      test_multi();
      test_zero_frames();
      test_random();
      test_abort();
      test_async_reset();
`ifdef CNN_SEQ_WATCHDOG_EN
      test_watchdog();
`else
      test_no_watchdog();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: got simulation time %0t expected completion", $time);
      $fatal(1, "bench did not complete");
   end

endmodule
